decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit instruction decoder.
- Accepts instruction words over a valid/ready stream and emits one registered, field-split decode record per instruction.
- Supports two-word instructions, where an extension word carries a full-width immediate.
- Sits between instruction fetch and the execute/register-read stage; has one output register stage with full backpressure.

Parameters:
- IW, 16, instruction word width in bits.
- OPC_W, 4, opcode field width (MSBs of the word).
- RA_W, 3, register-address field width (rd, rs1, rs2).
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops any partial or held instruction.
- in_valid  in  1  instr holds a valid word.
- in_ready  out  1  decoder accepts the word this cycle.
- instr  in  IW  instruction or extension word.
- out_valid  out  1  decode record valid.
- out_ready  in  1  consumer accepts the record.
- op_class  out  3  class code, values from the package.
- alu_op  out  3  opcode[2:0] for ALU classes, else 0.
- rd  out  RA_W  destination register.
- rs1  out  RA_W  source register 1.
- rs2  out  RA_W  source register 2.
- imm  out  IW  sign-extended short immediate, or the extension word.
- illegal  out  1  opcode is undefined.
- stat_dec  out  CNT_W  instructions emitted (optional feature only).
- stat_ill  out  CNT_W  illegal instructions emitted (optional feature only).

Behaviour:
- Field layout, MSB down: opcode[IW-1 -: OPC_W], rd, rs1, then short field SF of width IW-OPC_W-2*RA_W.
  - rs2 = top RA_W bits of SF.
  - imm = SF sign-extended to IW.
  - Defaults give rd[11:9], rs1[8:6], rs2[5:3], SF[5:0].
  - IW-OPC_W-2*RA_W < RA_W+1 is a configuration error.
- Opcode map:
  - 0 NOP.
  - 1-7 ALU reg-reg (alu_op = opcode[2:0]).
  - 8 ALUI.
  - 9 LOAD.
  - A STORE.
  - B BRANCH.
  - C JUMP.
  - D, E ILLEGAL: class NOP, illegal=1.
  - F LDI: two-word instruction.
- Reset: state IDLE; out_valid=0; all record fields 0; illegal=0; counters 0.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !flush.
  - A word transfers on in_valid && in_ready.
  - A record retires on out_valid && out_ready.
  - Record fields stay stable while out_valid && !out_ready.
- Latency: a one-word instruction accepted in cycle N gives out_valid in N+1.
- Throughput: one instruction per cycle under continuous ready.
- FSM states: IDLE, EXT.
  - IDLE, accept opcode F: latch rd/rs1 into a hold register, go to EXT, no record emitted.
  - IDLE, accept any other opcode: load the output record.
  - EXT, accept next word: emit LDI record with imm = that word verbatim, rs2=0, alu_op=0; return to IDLE.
- An extension word is never decoded as an opcode.
- Simultaneous retire and accept: the output register reloads in the same cycle with no bubble.
- flush: state IDLE, out_valid=0, hold register discarded; the word on instr that cycle is not accepted.
- Reset asserted mid-operation: immediate return to reset values, including while in EXT.

Optional Feature:
- Macro: DECODER_PIPE_STATS_EN.
- Defined:
  - stat_dec increments on every record retire.
  - stat_ill also increments when that retire has illegal=1.
  - Both counters saturate at all-ones, are cleared by reset only, and are unaffected by flush.
- Undefined: no counter flops; stat_dec and stat_ill tied to 0.

Decomposition:
- Package decoder_pkg:
  - op_class encoding: NOP=0, ALU=1, ALUI=2, LOAD=3, STORE=4, BRANCH=5, JUMP=6, LDI=7.
  - opcode constants, including OPC_LDI=4'hF.
  - FSM state typedef.
- Sub-module decoder_fields: purely combinational opcode/field split and sign extension, instanced once.
- decoder_pipe owns the FSM, hold register, output register and counters.

Test Plan:
- Reset release, then instr=16'h025a with out_ready=1 -> next cycle: op_class NOP, rd=1, rs1=1, rs2=3, imm=16'h001A, illegal=0.
- instr=16'h1E7F (ALU, alu_op=1) with out_ready=0 for 3 cycles -> record stable; in_ready=0; imm=16'hFFFF; releases on the first out_ready=1.
- Words 16'hF400 then 16'hBEEF -> exactly one record: op_class LDI, rd=2, imm=16'hBEEF; no record after the first word.
- 16'hF400, then flush=1 -> IDLE; next 16'h8041 decodes as ALUI with rd=0, rs1=1, imm=1.
- Back-to-back stream of 8 words with out_ready=1 -> 8 records in 8 consecutive cycles, no bubbles. With DECODER_PIPE_STATS_EN and two D/E opcodes in the stream: stat_dec=8, stat_ill=2.
- reset pulsed low while in EXT with out_valid=1 -> out_valid=0 and fields 0 asynchronously; first word after release decodes as a fresh opcode.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the pipelined instruction decoder.
package decoder_pkg;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_ALUI   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_LDI    = 3'd7
  } op_class_t;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_ALUI   = 4'h8;
  localparam logic [3:0] OPC_LOAD   = 4'h9;
  localparam logic [3:0] OPC_STORE  = 4'hA;
  localparam logic [3:0] OPC_BRANCH = 4'hB;
  localparam logic [3:0] OPC_JUMP   = 4'hC;
  localparam logic [3:0] OPC_ILL0   = 4'hD;
  localparam logic [3:0] OPC_ILL1   = 4'hE;
  localparam logic [3:0] OPC_LDI    = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_EXT
  } state_t;

  function automatic op_class_t opc_class(input logic [3:0] opc);
    op_class_t cls;
    case (opc)
      OPC_NOP, OPC_ILL0, OPC_ILL1: cls = CLS_NOP;
      OPC_ALUI:                    cls = CLS_ALUI;
      OPC_LOAD:                    cls = CLS_LOAD;
      OPC_STORE:                   cls = CLS_STORE;
      OPC_BRANCH:                  cls = CLS_BRANCH;
      OPC_JUMP:                    cls = CLS_JUMP;
      OPC_LDI:                     cls = CLS_LDI;
      default:                     cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/decoder_fields.sv
// Combinational field split, opcode classification and short-immediate sign extension.
module decoder_fields
  import decoder_pkg::*;
#(
  parameter int IW    = 16,
  parameter int OPC_W = 4,
  parameter int RA_W  = 3
) (
  input  logic [IW-1:0]   instr,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [IW-1:0]   imm,
  output logic [2:0]      op_class,
  output logic [2:0]      alu_op,
  output logic            illegal,
  output logic            is_ldi
);

  localparam int SF_W = IW - OPC_W - 2*RA_W;

  logic [OPC_W-1:0] opcode;
  logic [SF_W-1:0]  sf;
  op_class_t        cls;

  always_comb begin
    opcode   = instr[IW-1 -: OPC_W];
    rd       = instr[IW-OPC_W-1 -: RA_W];
    rs1      = instr[IW-OPC_W-RA_W-1 -: RA_W];
    sf       = instr[SF_W-1:0];
    rs2      = sf[SF_W-1 -: RA_W];
    imm      = {{(IW-SF_W){sf[SF_W-1]}}, sf};
    cls      = opc_class(opcode[3:0]);
    op_class = cls;
    alu_op   = (cls == CLS_ALU) ? opcode[2:0] : '0;
    illegal  = (opcode[3:0] == OPC_ILL0) || (opcode[3:0] == OPC_ILL1);
    is_ldi   = (opcode[3:0] == OPC_LDI);
  end

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined instruction decoder with valid/ready stream, two-word LDI and one output register.
// Optional retire statistics counters enabled by defining DECODER_PIPE_STATS_EN.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IW    = 16,
  parameter int OPC_W = 4,
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       op_class,
  output logic [2:0]       alu_op,
  output logic [RA_W-1:0]  rd,
  output logic [RA_W-1:0]  rs1,
  output logic [RA_W-1:0]  rs2,
  output logic [IW-1:0]    imm,
  output logic             illegal,
  output logic [CNT_W-1:0] stat_dec,
  output logic [CNT_W-1:0] stat_ill
);

  state_t          state, state_nxt;
  logic            accept, retire;
  logic            load_dec, load_ldi, load_hold;
  logic [RA_W-1:0] hold_rd, hold_rs1;

  logic [RA_W-1:0] f_rd, f_rs1, f_rs2;
  logic [IW-1:0]   f_imm;
  logic [2:0]      f_class, f_alu;
  logic            f_ill, f_is_ldi;

  decoder_fields #(.IW(IW), .OPC_W(OPC_W), .RA_W(RA_W)) u_fields (
    .instr    (instr),
    .rd       (f_rd),
    .rs1      (f_rs1),
    .rs2      (f_rs2),
    .imm      (f_imm),
    .op_class (f_class),
    .alu_op   (f_alu),
    .illegal  (f_ill),
    .is_ldi   (f_is_ldi)
  );

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // accept already excludes flush, so flush only needs to force IDLE here
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE: if (f_is_ldi) state_nxt = ST_EXT;
        ST_EXT:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_hold = accept && (state == ST_IDLE) && f_is_ldi;
    load_dec  = accept && (state == ST_IDLE) && !f_is_ldi;
    load_ldi  = accept && (state == ST_EXT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_rd  <= '0;
      hold_rs1 <= '0;
    end else if (flush) begin
      hold_rd  <= '0;
      hold_rs1 <= '0;
    end else if (load_hold) begin
      hold_rd  <= f_rd;
      hold_rs1 <= f_rs1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      op_class  <= '0;
      alu_op    <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      illegal   <= 1'b0;
    end else if (load_dec) begin
      out_valid <= 1'b1;
      op_class  <= f_class;
      alu_op    <= f_alu;
      rd        <= f_rd;
      rs1       <= f_rs1;
      rs2       <= f_rs2;
      imm       <= f_imm;
      illegal   <= f_ill;
    end else if (load_ldi) begin
      out_valid <= 1'b1;
      op_class  <= CLS_LDI;
      alu_op    <= '0;
      rd        <= hold_rd;
      rs1       <= hold_rs1;
      rs2       <= '0;
      imm       <= instr;
      illegal   <= 1'b0;
    end else if (retire || flush) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODER_PIPE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_dec <= '0;
      stat_ill <= '0;
    end else if (retire) begin
      if (stat_dec != '1)           stat_dec <= stat_dec + 1'b1;
      if (illegal && stat_ill != '1) stat_ill <= stat_ill + 1'b1;
    end
  end
`else
  assign stat_dec = '0;
  assign stat_ill = '0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized and directed bench for decoder_pipe against an instruction-level reference model.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [2:0]  op_class, alu_op, rd, rs1, rs2;
  logic [15:0] imm, stat_dec, stat_ill;

  always #5 clk = ~clk;

  decoder_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .op_class(op_class),
    .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .illegal(illegal),
    .stat_dec(stat_dec), .stat_ill(stat_ill)
  );

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  alu;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic        ill;
  } rec_t;

  int unsigned vectors = 0, miscompares = 0;
  rec_t        m_rec;
  bit          m_valid, m_pending;
  logic [15:0] m_hold;
  int unsigned m_dec, m_ill;
  rec_t        got;

  assign got = {op_class, alu_op, rd, rs1, rs2, imm, illegal};

  function automatic rec_t decode(input logic [15:0] w);
    rec_t r;
    int opc, sf;
    opc   = int'(w[15:12]);
    sf    = int'(w[5:0]);
    if (sf >= 32) sf = sf - 64;
    r     = '0;
    r.rd  = w[11:9];
    r.rs1 = w[8:6];
    r.rs2 = w[5:3];
    r.imm = 16'(sf);
    if (opc >= 1 && opc <= 7) begin
      r.cls = 3'(1);
      r.alu = 3'(opc);
    end else if (opc >= 8 && opc <= 12) begin
      r.cls = 3'(opc - 6);
    end
    r.ill = (opc == 13 || opc == 14);
    return r;
  endfunction

  function automatic logic [15:0] exp_stat(input int unsigned n);
`ifdef DECODER_PIPE_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n == 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    m_rec = '0; m_valid = 0; m_pending = 0; m_hold = '0; m_dec = 0; m_ill = 0;
  endtask

  // Drive one cycle's inputs at the falling edge, advance the model, return at the next falling edge.
  task automatic step(input bit v, input logic [15:0] w, input bit ord, input bit fl);
    bit acc;
    in_valid = v; instr = w; out_ready = ord; flush = fl;
    acc = v && (!m_valid || ord) && !fl;
    if (m_valid && ord) begin
      m_dec++;
      if (m_rec.ill) m_ill++;
      m_valid = 0;
    end
    if (fl) begin
      m_valid = 0; m_pending = 0;
    end else if (acc) begin
      if (m_pending) begin
        m_rec = '0; m_rec.cls = 3'd7; m_rec.rd = m_hold[11:9]; m_rec.rs1 = m_hold[8:6];
        m_rec.imm = w; m_valid = 1; m_pending = 0;
      end else if (w[15:12] == 4'hF) begin
        m_pending = 1; m_hold = w;
      end else begin
        m_rec = decode(w); m_valid = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 0; in_valid = 0; out_ready = 0; instr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    vectors++; if (got !== '0) begin miscompares++; $display("FAIL reset_rec got=%h exp=0", got); end
    vectors++; if (stat_dec !== 16'h0 || stat_ill !== 16'h0) begin
      miscompares++; $display("FAIL reset_stats got=%h/%h exp=0/0", stat_dec, stat_ill); end
    reset = 1'b1;
  endtask

  task automatic test_nop_decode();
    step(1, 16'h025a, 1, 0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL nop_valid got=%b exp=1", out_valid); end
    vectors++; if (got !== m_rec || imm !== 16'h001A || rs2 !== 3'd3) begin
      miscompares++; $display("FAIL nop_rec got=%h exp=%h", got, m_rec); end
    step(0, 16'h0, 1, 0);
  endtask

  task automatic test_backpressure();
    step(1, 16'h1E7F, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 16'h9123, 0, 0);
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold valid=%b ready=%b exp 1/0", out_valid, in_ready); end
      vectors++; if (got !== m_rec || imm !== 16'hFFFF || alu_op !== 3'd1) begin
        miscompares++; $display("FAIL bp_rec got=%h exp=%h", got, m_rec); end
    end
    step(0, 16'h0, 1, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_ldi();
    step(1, 16'hF400, 1, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ldi_first got=%b exp=0", out_valid); end
    step(1, 16'hBEEF, 1, 0);
    vectors++; if (out_valid !== 1'b1 || got !== m_rec || op_class !== 3'd7 || rd !== 3'd2 || imm !== 16'hBEEF) begin
      miscompares++; $display("FAIL ldi_rec valid=%b got=%h exp=%h", out_valid, got, m_rec); end
    step(0, 16'h0, 1, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ldi_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    step(1, 16'hF400, 1, 0);
    step(1, 16'h3333, 1, 1);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL flush_state valid=%b ready=%b exp 0/0", out_valid, in_ready); end
    step(1, 16'h8041, 1, 0);
    vectors++; if (out_valid !== 1'b1 || got !== m_rec || op_class !== 3'd2 || rs1 !== 3'd1 || imm !== 16'h0001) begin
      miscompares++; $display("FAIL flush_next valid=%b got=%h exp=%h", out_valid, got, m_rec); end
    step(0, 16'h0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [8];
    int unsigned run = 0;
    words = '{16'h1249, 16'hD123, 16'h9ABC, 16'hE456, 16'h2FFF, 16'hA001, 16'hC7C0, 16'h0003};
    pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      step(1, words[i], 1, 0);
      if (out_valid === 1'b1) run++;
      vectors++; if (got !== m_rec) begin miscompares++; $display("FAIL b2b_rec[%0d] got=%h exp=%h", i, got, m_rec); end
    end
    vectors++; if (run != 8) begin miscompares++; $display("FAIL b2b_run got=%0d exp=8", run); end
    step(0, 16'h0, 1, 0);
    vectors++; if (stat_dec !== exp_stat(8) || stat_ill !== exp_stat(2) || m_ill != 2) begin
      miscompares++; $display("FAIL b2b_stats got=%0d/%0d exp=%0d/%0d", stat_dec, stat_ill, exp_stat(8), exp_stat(2)); end
  endtask

  task automatic test_reset_mid_op();
    step(1, 16'h5A5A, 0, 0);
    pulse_reset();
    vectors++; if (out_valid !== 1'b0 || got !== '0) begin
      miscompares++; $display("FAIL async_rst valid=%b got=%h exp 0/0", out_valid, got); end
    @(negedge clk);
    reset = 1'b1;
    step(1, 16'hF400, 1, 0);
    pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1, 16'h9ABC, 1, 0);
    vectors++; if (out_valid !== 1'b1 || got !== m_rec || op_class !== 3'd3) begin
      miscompares++; $display("FAIL ext_rst valid=%b got=%h exp=%h", out_valid, got, m_rec); end
    step(0, 16'h0, 1, 0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int unsigned i = 0; i < 400; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      vectors++; if (out_valid !== m_valid) begin
        miscompares++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, m_valid); end
      vectors++; if (got !== m_rec) begin miscompares++; $display("FAIL rnd_rec[%0d] got=%h exp=%h", i, got, m_rec); end
      vectors++; if (in_ready !== ((!m_valid || out_ready) && !flush)) begin
        miscompares++; $display("FAIL rnd_ready[%0d] got=%b", i, in_ready); end
      vectors++; if (stat_dec !== exp_stat(m_dec) || stat_ill !== exp_stat(m_ill)) begin
        miscompares++; $display("FAIL rnd_stats[%0d] got=%0d/%0d exp=%0d/%0d", i, stat_dec, stat_ill, exp_stat(m_dec), exp_stat(m_ill)); end
    end
  endtask

  initial begin
    test_reset();
    test_nop_decode();
    test_backpressure();
    test_ldi();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
